down_timer: RTL and testbench

//  Loadable WIDTH-bit down-counting timer; the counterpart of the free-running up counter.

---
 rtl/down_timer_pkg.sv | 14 +
 rtl/down_timer_tick_gen.sv | 44 ++++
 rtl/down_timer.sv | 135 +++++++++++++
 tb/tb_down_timer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// down_timer_pkg
//   Shared definitions for the down_timer block: state register width and
//   the IDLE/RUN/HOLD state encodings used by the top level.
package down_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_tick_gen.sv
// tick_gen
//   Prescale counter for down_timer. Counts 0..PRESCALE-1 while enabled and
//   raises tick (combinationally) on the last count, wrapping back to 0 on
//   that edge. clr returns the counter to 0 and has priority over en.
// Ports
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   en    in  advance the prescaler this edge
//   clr   in  force the prescaler to 0 this edge
//   tick  out high when the enabled prescaler is on its last count
module tick_gen
    import down_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// down_timer
//   Loadable WIDTH-bit down-counting timer. load captures load_val, start
//   begins a countdown from the current count, every PRESCALE enabled cycles
//   the count drops by one, and reaching zero produces a one-cycle done pulse.
//   pause freezes the countdown, stop aborts it leaving count untouched.
//   Edge priority: load > stop > start > pause > tick.
// Parameters
//   WIDTH     count width (>=2)
//   PRESCALE  clk cycles per decrement (>=1)
// Ports
//   clk, rst (async, active-high), load, load_val[WIDTH], start, pause, stop
//   count[WIDTH] out, busy out (RUN or HOLD), done out (expiry pulse)
// Configuration
//   DOWN_TIMER_AUTO_RELOAD_EN: load also captures a reload value; on expiry
//   the count restarts from it and the timer keeps running.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             done_n;
    logic             run_en;
    logic             pre_clr;
    logic             tick;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= '0;
        end else if (load) begin
            reload <= load_val;
        end
    end
`endif

    // The edge that leaves HOLD (pause low) already counts as a running
    // edge, so a pause sampled high on N edges delays expiry by exactly N.
    assign run_en  = ((state == RUN) || (state == HOLD)) && !pause && !load && !stop;
    assign pre_clr = load || stop || ((state == IDLE) && start);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (run_en),
        .clr (pre_clr),
        .tick(tick)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        done_n  = 1'b0;
        if (load) begin
            count_n = load_val;
            state_n = IDLE;
        end else if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_n = RUN;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (pause) begin
                        state_n = HOLD;
                    end else begin
                        state_n = RUN;
                        if (tick) begin
                            // count==0 while running only arises from a zero
                            // reload value; treat it as an expiry so the
                            // count can never wrap.
                            if (count <= WIDTH'(1)) begin
                                done_n = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                                if (reload != '0) begin
                                    count_n = reload;
                                end else begin
                                    count_n = '0;
                                    state_n = IDLE;
                                end
`else
                                count_n = '0;
                                state_n = IDLE;
`endif
                            end else begin
                                count_n = count - WIDTH'(1);
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            done  <= done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] c1, c4;
    logic       b1, b4, d1, d4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    down_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .stop(stop), .count(c1), .busy(b1), .done(d1)
    );

    down_timer #(.WIDTH(4), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .stop(stop), .count(c4), .busy(b4), .done(d4)
    );

    // Reference model: index 0 is the PRESCALE=1 timer, index 1 the PRESCALE=4 one.
    int         pre [2] = '{1, 4};
    logic [3:0] m_cnt [2];
    logic [3:0] m_rel [2];
    int         m_phase [2];
    bit         m_run [2];
    bit         m_done [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 4'd0; m_rel[i] = 4'd0; m_phase[i] = 0;
            m_run[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit l, input logic [3:0] lv, input bit s,
                              input bit p, input bit st);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (l) begin
                m_cnt[i] = lv; m_rel[i] = lv; m_run[i] = 1'b0; m_phase[i] = 0;
            end else if (st) begin
                m_run[i] = 1'b0; m_phase[i] = 0;
            end else if (!m_run[i]) begin
                if (s) begin
                    if (m_cnt[i] == 4'd0) m_done[i] = 1'b1;
                    else begin m_run[i] = 1'b1; m_phase[i] = 0; end
                end
            end else if (!p) begin
                m_phase[i]++;
                if (m_phase[i] == pre[i]) begin
                    m_phase[i] = 0;
                    if (m_cnt[i] <= 4'd1) begin
                        m_done[i] = 1'b1;
                        if (AUTO && m_rel[i] != 4'd0) m_cnt[i] = m_rel[i];
                        else begin m_cnt[i] = 4'd0; m_run[i] = 1'b0; end
                    end else begin
                        m_cnt[i] = m_cnt[i] - 4'd1;
                    end
                end
            end
        end
    endtask

    function automatic logic [11:0] mvec();
        return {m_cnt[0], m_run[0], m_done[0], m_cnt[1], m_run[1], m_done[1]};
    endfunction

    function automatic logic [11:0] dvec();
        return {c1, b1, d1, c4, b4, d4};
    endfunction

    // Drive inputs away from the edge, clock once, advance the model, settle.
    task automatic cyc(input bit l, input int lv, input bit s, input bit p, input bit st);
        logic [3:0] v;
        v = lv[3:0];
        @(negedge clk);
        load = l; load_val = v; start = s; pause = p; stop = st;
        @(posedge clk);
        model_edge(l, v, s, p, st);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (dvec() !== mvec()) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", dvec(), mvec());
        end
        @(negedge clk); rst = 1'b0;
        cyc(1, 5, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({c4, b4} !== {4'd5, 1'b1}) begin
            failures++; $display("FAIL reset_prerun got=%h/%b exp=5/1", c4, b4);
        end
        @(negedge clk); #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dvec() !== 12'h000) begin
            failures++; $display("FAIL reset_async got=%h exp=000", dvec());
        end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (dvec() !== mvec()) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", dvec(), mvec());
        end
    endtask

    task automatic test_prescale1();
        logic [3:0] ec [5];
        bit         eb [5];
        bit         ed [5] = '{0, 0, 0, 1, 0};
        if (AUTO) begin ec = '{3, 2, 1, 3, 2}; eb = '{1, 1, 1, 1, 1}; end
        else      begin ec = '{3, 2, 1, 0, 0}; eb = '{1, 1, 1, 0, 0}; end
        cyc(1, 3, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, (k == 0), 0, 0);
            checks++;
            if ({c1, b1, d1} !== {ec[k], eb[k], ed[k]}) begin
                failures++;
                $display("FAIL p1_seq E%0d got=%h/%b/%b exp=%h/%b/%b", k, c1, b1, d1, ec[k], eb[k], ed[k]);
            end
            checks++;
            if (dvec() !== mvec()) begin
                failures++; $display("FAIL p1_model E%0d got=%h exp=%h", k, dvec(), mvec());
            end
        end
    endtask

    task automatic test_prescale4();
        logic [3:0] ec;
        bit         eb, ed;
        cyc(1, 2, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, (k == 0), 0, 0);
            ec = (k < 4) ? 4'd2 : (k < 8) ? 4'd1 : (AUTO ? 4'd2 : 4'd0);
            eb = (k < 8) || AUTO;
            ed = (k == 8);
            checks++;
            if ({c4, b4, d4} !== {ec, eb, ed}) begin
                failures++;
                $display("FAIL p4_seq E%0d got=%h/%b/%b exp=%h/%b/%b", k, c4, b4, d4, ec, eb, ed);
            end
            checks++;
            if (dvec() !== mvec()) begin
                failures++; $display("FAIL p4_model E%0d got=%h exp=%h", k, dvec(), mvec());
            end
        end
    endtask

    task automatic test_pause();
        int first_done = -1;
        cyc(1, 6, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0, 0, (k >= 3 && k <= 5), 0);
            if (d1 && first_done < 0) first_done = k;
            if (k >= 3 && k <= 5) begin
                checks++;
                if (c1 !== 4'd4) begin
                    failures++; $display("FAIL pause_hold E%0d got=%0d exp=4", k, c1);
                end
            end
            checks++;
            if (dvec() !== mvec()) begin
                failures++; $display("FAIL pause_model E%0d got=%h exp=%h", k, dvec(), mvec());
            end
        end
        checks++;
        if (first_done !== 9) begin
            failures++; $display("FAIL pause_delay got=E%0d exp=E9", first_done);
        end
    endtask

    task automatic test_zero_and_load_start();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if ({c1, b1, d1, c4, b4, d4} !== {4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL zero_start got=%h exp=%h", dvec(), {4'd0, 2'b01, 4'd0, 2'b01});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({d1, d4} !== 2'b00) begin
            failures++; $display("FAIL zero_pulse got=%b%b exp=00", d1, d4);
        end
        cyc(1, 5, 1, 0, 0);
        checks++;
        if ({c1, b1, d1} !== {4'd5, 1'b0, 1'b0}) begin
            failures++; $display("FAIL load_wins got=%h/%b/%b exp=5/0/0", c1, b1, d1);
        end
        checks++;
        if (dvec() !== mvec()) begin
            failures++; $display("FAIL load_wins_model got=%h exp=%h", dvec(), mvec());
        end
    endtask

    task automatic test_reload_and_stop();
        int         dones = 0;
        logic [3:0] held;
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (d1) dones++;
            checks++;
            if (dvec() !== mvec()) begin
                failures++; $display("FAIL reload_model E%0d got=%h exp=%h", k, dvec(), mvec());
            end
        end
        checks++;
        if (dones !== (AUTO ? 4 : 1) || b1 !== AUTO) begin
            failures++;
            $display("FAIL reload_dones got=%0d busy=%b exp=%0d busy=%b", dones, b1, AUTO ? 4 : 1, AUTO);
        end
        held = c1;
        cyc(0, 0, 0, 0, 1);
        checks++;
        if ({c1, b1, d1} !== {held, 1'b0, 1'b0}) begin
            failures++; $display("FAIL stop_hold got=%h/%b/%b exp=%h/0/0", c1, b1, d1, held);
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (dvec() !== mvec()) begin
            failures++; $display("FAIL stop_model got=%h exp=%h", dvec(), mvec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 9) == 0), $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 19) == 0));
            checks++;
            if (dvec() !== mvec()) begin
                failures++; $display("FAIL random cyc%0d got=%h exp=%h", k, dvec(), mvec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescale1();
        test_prescale4();
        test_pause();
        test_zero_and_load_start();
        test_reload_and_stop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
